// File: rtl/ui_pkg.sv
// Shared UI-block definitions: FSM state encoding for the LED stretcher.
package ui_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter; drop pulses when an increment is lost at max.
module sat_updown_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat,
  output logic             drop
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  assign sat  = (count == MAX_COUNT);
  assign drop = inc && !dec && sat;

  // Simultaneous inc and dec cancel; dec at zero is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/event_led_stretcher.sv
// Stretches one-cycle event strobes into counted LED blinks with a dark gap.
// Optional LED dimming during blinks is built when EVENT_LED_PWM_EN is defined.
module event_led_stretcher
  import ui_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5_000_000,
  parameter int unsigned GAP_CYCLES = 5_000_000,
  parameter int unsigned CNT_WIDTH  = 24,
  parameter int unsigned PEND_WIDTH = 4,
  parameter int unsigned PWM_WIDTH  = 4,
  parameter int unsigned PWM_DUTY   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ev,
  output logic                  led,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  overflow
);

  localparam logic [CNT_WIDTH-1:0] ON_LAST  = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (ON_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_phase
    $error("event_led_stretcher: ON_CYCLES and GAP_CYCLES must be >= 1");
  end
  if (PWM_WIDTH < 1 || PWM_DUTY > (1 << PWM_WIDTH)) begin : g_bad_pwm
    $error("event_led_stretcher: PWM_DUTY exceeds PWM period");
  end

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 pend_inc, pend_dec;
  logic                 pend_sat, pend_drop;
  logic                 led_d;

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next state, phase counter and pending-queue control.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt + CNT_WIDTH'(1);
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (ev) state_d = ON;
      end
      ON: begin
        pend_inc = ev;
        if (cnt == ON_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d = '0;
          // An event on the last gap cycle is consumed directly by the next blink.
          pend_dec = (pending != '0) && !ev;
          state_d  = ((pending != '0) || ev) ? ON : IDLE;
        end else begin
          pend_inc = ev;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  sat_updown_counter #(
    .WIDTH(PEND_WIDTH)
  ) u_pending (
    .clk  (clk),
    .rst  (rst),
    .inc  (pend_inc),
    .dec  (pend_dec),
    .count(pending),
    .sat  (pend_sat),
    .drop (pend_drop)
  );

  drop_implies_sat : assert property (@(posedge clk) disable iff (rst) pend_drop |-> pend_sat);

`ifdef EVENT_LED_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt + PWM_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt_d;
  end

  // led follows the PWM value that will be current after this edge.
  assign led_d = (state_d == ON) && (32'(pwm_cnt_d) < PWM_DUTY);
`else
  assign led_d = (state_d == ON);
`endif

  // Registered LED, busy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      led      <= led_d;
      busy     <= (state_d != IDLE);
      overflow <= overflow | pend_drop;
    end
  end

endmodule

// File: tb/tb_event_led_stretcher.sv
// Randomized and directed checks of event_led_stretcher against a blink-schedule model.
module tb_event_led_stretcher;

  localparam int unsigned ON_C   = 4;
  localparam int unsigned GAP_C  = 3;
  localparam int unsigned PER_C  = ON_C + GAP_C;
  localparam int unsigned PEND_W = 2;
  localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;
  localparam int unsigned PWM_W  = 2;
  localparam int unsigned PWM_D  = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ev  = 1'b0;
  logic              led, busy, overflow;
  logic [PEND_W-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Model: a blink occupies edges [start, start+PER_C); decisions are by elapsed time.
  int now = 0;
  int start = 0;
  int rst_time = 0;
  bit active = 1'b0;
  int pend = 0;
  bit ovf = 1'b0;

  event_led_stretcher #(
    .ON_CYCLES (ON_C),
    .GAP_CYCLES(GAP_C),
    .CNT_WIDTH (3),
    .PEND_WIDTH(PEND_W),
    .PWM_WIDTH (PWM_W),
    .PWM_DUTY  (PWM_D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev      (ev),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] expv();
    bit on;
    bit lit;
    on = active && ((now - start) < int'(ON_C));
`ifdef EVENT_LED_PWM_EN
    lit = on && (((now - rst_time) % (1 << PWM_W)) < int'(PWM_D));
`else
    lit = on;
`endif
    return {lit, active, 2'(pend), ovf};
  endfunction

  function automatic logic [4:0] obsv();
    return {led, busy, pending, overflow};
  endfunction

  task automatic tick(input bit r, input bit e);
    rst = r;
    ev  = e;
    @(posedge clk);
    now++;
    if (r) begin
      active = 1'b0; pend = 0; ovf = 1'b0; rst_time = now;
    end else if (!active) begin
      if (e) begin active = 1'b1; start = now; end
    end else if (now - start == int'(PER_C)) begin
      if (pend > 0 || e) begin
        start = now;
        if (pend > 0 && !e) pend--;
      end else begin
        active = 1'b0;
      end
    end else if (e) begin
      if (pend == int'(PEND_MAX)) ovf = 1'b1;
      else pend++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, (i == 1));
      checks++;
      if (obsv() !== 5'b00000) begin
        errors++;
        $display("FAIL reset t=%0d got %b exp %b", now, obsv(), 5'b00000);
      end
    end
  endtask

  task automatic test_single();
    tick(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL single t=%0d got %b exp %b", now, obsv(), expv());
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 26; i++) begin
      tick(1'b0, (i < 3));
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL burst t=%0d got %b exp %b", now, obsv(), expv());
      end
    end
  endtask

  task automatic test_overflow();
    int rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 36; i++) begin
      tick(1'b0, (i == 0) || (i >= 2 && i <= 5));
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL overflow t=%0d got %b exp %b", now, obsv(), expv());
      end
      if (led && !prev) rises++;
      prev = led;
    end
`ifndef EVENT_LED_PWM_EN
    checks++;
    if (rises !== 4) begin
      errors++;
      $display("FAIL overflow_blinks got %0d exp %0d", rises, 4);
    end
`endif
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b exp %b", overflow, 1'b1);
    end
  endtask

  task automatic test_coincident();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, (i == 0) || (i == int'(PER_C)));
      checks++;
      if (obsv() !== expv() || (i <= int'(PER_C) + 2 && busy !== 1'b1)) begin
        errors++;
        $display("FAIL coincident t=%0d got %b exp %b", now, obsv(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) begin
      tick((i == 2), (i == 0) || (i == 2) || (i == 4));
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL reset_mid t=%0d got %b exp %b", now, obsv(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit e;
    for (int i = 0; i < 800; i++) begin
      e = (i % 200 < 40) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
      tick(($urandom_range(0, 149) == 0), e);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL random t=%0d got %b exp %b", now, obsv(), expv());
      end
    end
  endtask

  task automatic go_idle();
    for (int i = 0; i < 40 && active; i++) tick(1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    repeat (5) tick(1'b0, 1'b0);
    test_single();
    go_idle();
    test_burst();
    go_idle();
    test_overflow();
    go_idle();
    tick(1'b1, 1'b0);
    test_coincident();
    go_idle();
    test_reset_mid();
    go_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_led_stretcher.md
# event_led_stretcher

Output-side companion to the pushbutton debouncer. It takes one-cycle event strobes, such as a debounced posedge pulse or a sequence-detector hit, and turns each one into a human-visible LED blink of fixed on-time, followed by a fixed dark gap. Events that arrive while a blink is in progress are queued in a saturating counter and replayed as separate blinks, so the LED shows how many events occurred. It sits between the detection logic and the board LED pins.

## Interface
- ON_CYCLES, 5_000_000: LED on-time per blink, in clk cycles; valid range 1..2^CNT_WIDTH.
- GAP_CYCLES, 5_000_000: dark time after each blink, in clk cycles; valid range 1..2^CNT_WIDTH.
- CNT_WIDTH, 24: width of the shared phase counter.
- PEND_WIDTH, 4: width of the pending-event counter; it saturates at 2^PEND_WIDTH-1.
- PWM_WIDTH, 4: width of the PWM counter (used only with EVENT_LED_PWM_EN).
- PWM_DUTY, 4: number of on-cycles per PWM period (used only with EVENT_LED_PWM_EN).
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- ev  in  1  event strobe. Every cycle in which ev is high counts as one event.
- led  out  1  LED drive, registered.
- busy  out  1  high whenever the state is not IDLE.
- pending  out  PEND_WIDTH  number of queued events not yet started.
- overflow  out  1  sticky flag; set when an event is dropped at saturation. Cleared only by rst.

## Operation
- The FSM has three states: IDLE, ON and GAP. One phase counter `cnt` is shared by ON and GAP.
- IDLE:
  - led=0 and pending=0 (invariant).
  - ev=1 moves the FSM to ON and clears cnt. The event is consumed directly and is not queued.
- ON:
  - led=1 (see Configuration).
  - cnt increments each cycle.
  - At cnt==ON_CYCLES-1 the FSM moves to GAP and clears cnt.
- GAP:
  - led=0 and cnt increments.
  - At cnt==GAP_CYCLES-1, if pending>0 or ev=1, the FSM moves to ON and clears cnt. Otherwise it moves to IDLE.
- Pending update rules:
  - ev in ON, or in a non-final GAP cycle: pending+1.
  - ev when pending is already at max: pending holds and overflow is set to 1.
  - Final GAP cycle with pending>0 and ev=0: pending-1.
  - Final GAP cycle with pending>0 and ev=1: pending unchanged (one event in, one out).
  - Final GAP cycle with pending==0 and ev=1: the event is consumed directly and pending stays 0.
- Unused state encodings go to IDLE.
- Reset values: state=IDLE, cnt=0, led=0, busy=0, pending=0, overflow=0, PWM counter=0.

## Timing
- ev high before clock edge t makes led high from edge t onward, a latency of one cycle.
- led then stays high for exactly ON_CYCLES cycles and low for at least GAP_CYCLES cycles.
- Back-to-back blinks have period ON_CYCLES+GAP_CYCLES, with no IDLE cycle between them.
- busy and pending are registered and update on the same edge as the state.
- rst has priority over everything. An ev sampled at a reset edge is discarded.
- Reset mid-blink forces all outputs to their reset values on the next edge.

## Configuration
- EVENT_LED_PWM_EN defined:
  - A free-running PWM_WIDTH-bit counter is instantiated.
  - During ON, led = (pwm_cnt < PWM_DUTY), which dims the LED.
  - led=0 outside ON.
- EVENT_LED_PWM_EN undefined:
  - The PWM counter is not instantiated.
  - led is solid 1 for the whole ON state.
  - PWM_WIDTH and PWM_DUTY are ignored.

## Structure
- Shared package `ui_pkg`: state encodings IDLE=2'b00, ON=2'b01, GAP=2'b10, plus the state-vector width constant.
- Sub-module `sat_updown_counter`, parameterised by width:
  - inputs: inc, dec.
  - outputs: count, sat, and a drop pulse when inc arrives at max without dec.
  - used for the pending counter; its drop pulse sets overflow.

## Test plan
Directed scenarios use ON_CYCLES=4, GAP_CYCLES=3, PEND_WIDTH=2 unless stated.
- Single event: ev pulse at cycle 10 -> led=1 in cycles 11-14, led=0 in cycles 15-17, busy=0 from cycle 18, pending=0 throughout.
- Burst from IDLE: ev high in cycles 10, 11, 12 -> pending reads 1 then 2; three blinks, each 4 on / 3 off; busy high for 21 cycles, then IDLE.
- Overflow: ev in IDLE at cycle 10, then ev in each of ON cycles 12-15 -> pending=3, overflow=1 and stays 1; exactly 4 blinks total.
- Coincident event at end of GAP: ev on the last GAP cycle with pending=0 -> ON on the next cycle, busy never drops, pending stays 0.
- Reset mid-blink: rst high in the second ON cycle -> next cycle led=0, busy=0, pending=0, overflow=0; a later ev produces a normal 4-cycle blink.
- PWM mode: with EVENT_LED_PWM_EN defined, PWM_WIDTH=2, PWM_DUTY=1 -> during ON, led is high 1 of every 4 cycles, aligned to pwm_cnt==0. The same stimulus without the macro gives a solid 4-cycle high.
